// File: rtl/segment_ctrl_pkg.sv
// Shared settings for the segment sequencer: trigger-mode encodings, controller
// state enum and default repetition-field width.
package segment_ctrl_pkg;

    localparam int unsigned REP_W_DEFAULT = 16;

    localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] MODE_GPIO      = 8'h02;
    localparam logic [7:0] MODE_EXT       = 8'h03;
    localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

    typedef enum logic [1:0] {
        StRun,
        StArmed,
        StStopped
    } seg_state_e;

    function automatic logic mode_valid(input logic [7:0] mode);
        case (mode)
            MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT, MODE_IMMEDIATE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/segment_trigger.sv
// Collapses the armed request's trigger condition (loop wrap, time compare or
// GPIO rising edge) into a single-cycle trigger strobe.
module segment_trigger
    import segment_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        armed,
    input  logic [7:0]  mode,
    input  logic [63:0] value,
    input  logic [63:0] sys_time,
    input  logic [3:0]  gpio_in,
    input  logic        loop_end,
    output logic        trigger
);

    logic [3:0] gpio_q;
    logic [3:0] gpio_rise;

    // History runs regardless of arming so a level already high is never an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q <= '0;
        end else begin
            gpio_q <= gpio_in;
        end
    end

    assign gpio_rise = gpio_in & ~gpio_q;

    always_comb begin
        trigger = 1'b0;
        if (armed) begin
            case (mode)
                MODE_SYNC_IDX, MODE_EXT: trigger = loop_end;
                MODE_SYS_TIME:           trigger = (sys_time >= value);
                MODE_GPIO:               trigger = gpio_rise[value[1:0]];
                MODE_IMMEDIATE:          trigger = 1'b1;
                default:                 trigger = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/segment_ctrl.sv
// Segment sequencer: arms a requested segment, commits it on its trigger and
// counts repetitions of the active segment until stop or EXT auto-advance.
module segment_ctrl
    import segment_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SEGMENTS = 4,
    parameter int unsigned SEG_W        = $clog2(NUM_SEGMENTS),
    parameter int unsigned REP_W        = REP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              update,
    input  logic [SEG_W-1:0]  req_segment,
    input  logic [7:0]        transition_mode,
    input  logic [63:0]       transition_value,
    input  logic [REP_W-1:0]  rep,
    input  logic [63:0]       sys_time,
    input  logic [3:0]        gpio_in,
    input  logic              loop_end,
    output logic [SEG_W-1:0]  segment,
    output logic              seg_switch,
    output logic              pending,
    output logic              stop,
    output logic              err
);

    localparam logic [REP_W-1:0] REP_INF = '1;

    seg_state_e         state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               switch_q, switch_d;
    logic               stop_q, stop_d;
    logic               err_q, err_d;
    logic               ext_q, ext_d;
    logic [REP_W-1:0]   cnt_q, cnt_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [SEG_W-1:0]   req_seg_q, req_seg_d;
    logic [7:0]         req_mode_q, req_mode_d;
    logic [63:0]        req_value_q, req_value_d;
    logic [REP_W-1:0]   req_rep_q, req_rep_d;

    logic armed;
    logic trig;
    logic req_ok;
    logic commit;

    assign armed  = (state_q == StArmed);
    assign req_ok = update && mode_valid(transition_mode)
                    && (32'(req_segment) < NUM_SEGMENTS);
    // A fresh accepted request supersedes a trigger for the old one.
    assign commit = trig && !req_ok;

    segment_trigger u_trigger (
        .clk      (clk),
        .rst_n    (rst_n),
        .armed    (armed),
        .mode     (req_mode_q),
        .value    (req_value_q),
        .sys_time (sys_time),
        .gpio_in  (gpio_in),
        .loop_end (loop_end),
        .trigger  (trig)
    );

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        switch_d    = 1'b0;
        stop_d      = stop_q;
        err_d       = err_q;
        ext_d       = ext_q;
        cnt_d       = cnt_q;
        rep_d       = rep_q;
        req_seg_d   = req_seg_q;
        req_mode_d  = req_mode_q;
        req_value_d = req_value_q;
        req_rep_d   = req_rep_q;

        if (req_ok) begin
            req_seg_d   = req_segment;
            req_mode_d  = transition_mode;
            req_value_d = transition_value;
            req_rep_d   = rep;
            state_d     = StArmed;
            err_d       = 1'b0;
            ext_d       = 1'b0;
        end else if (update) begin
            err_d = 1'b1;
        end

        if (commit) begin
            seg_d    = req_seg_q;
            switch_d = 1'b1;
            cnt_d    = req_rep_q;
            rep_d    = req_rep_q;
            ext_d    = (req_mode_q == MODE_EXT);
            stop_d   = 1'b0;
            state_d  = StRun;
        end else if (loop_end && !stop_q && cnt_q != REP_INF) begin
            // Active segment keeps counting even while a new request is armed.
            if (cnt_q == '0) begin
                if (ext_q) begin
                    seg_d    = (seg_q == SEG_W'(NUM_SEGMENTS - 1)) ? '0 : seg_q + 1'b1;
                    switch_d = 1'b1;
                    cnt_d    = rep_q;
                end else begin
                    stop_d = 1'b1;
                    if (!req_ok && state_q == StRun) begin
                        state_d = StStopped;
                    end
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            seg_q       <= '0;
            switch_q    <= 1'b0;
            stop_q      <= 1'b0;
            err_q       <= 1'b0;
            ext_q       <= 1'b0;
            cnt_q       <= REP_INF;
            rep_q       <= REP_INF;
            req_seg_q   <= '0;
            req_mode_q  <= MODE_SYNC_IDX;
            req_value_q <= '0;
            req_rep_q   <= REP_INF;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            switch_q    <= switch_d;
            stop_q      <= stop_d;
            err_q       <= err_d;
            ext_q       <= ext_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            req_seg_q   <= req_seg_d;
            req_mode_q  <= req_mode_d;
            req_value_q <= req_value_d;
            req_rep_q   <= req_rep_d;
        end
    end

    assign segment    = seg_q;
    assign seg_switch = switch_q;
    assign pending    = armed;
    assign stop       = stop_q;
    assign err        = err_q;

endmodule

// File: tb/tb_segment_ctrl.sv
// Directed self-checking bench for segment_ctrl; a second 3-segment instance
// shares the stimulus to exercise the out-of-range segment check.
module tb_segment_ctrl;
    import segment_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        update;
    logic [1:0]  req_segment;
    logic [7:0]  transition_mode;
    logic [63:0] transition_value;
    logic [15:0] rep;
    logic [63:0] sys_time;
    logic [3:0]  gpio_in;
    logic        loop_end;

    logic [1:0]  segment;
    logic        seg_switch, pending, stop, err;
    logic [1:0]  segment3;
    logic        seg_switch3, pending3, stop3, err3;

    int n_assert = 0;
    int n_fail   = 0;

    segment_ctrl #(.NUM_SEGMENTS(4)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .update           (update),
        .req_segment      (req_segment),
        .transition_mode  (transition_mode),
        .transition_value (transition_value),
        .rep              (rep),
        .sys_time         (sys_time),
        .gpio_in          (gpio_in),
        .loop_end         (loop_end),
        .segment          (segment),
        .seg_switch       (seg_switch),
        .pending          (pending),
        .stop             (stop),
        .err              (err)
    );

    segment_ctrl #(.NUM_SEGMENTS(3)) u_dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .update           (update),
        .req_segment      (req_segment),
        .transition_mode  (transition_mode),
        .transition_value (transition_value),
        .rep              (rep),
        .sys_time         (sys_time),
        .gpio_in          (gpio_in),
        .loop_end         (loop_end),
        .segment          (segment3),
        .seg_switch       (seg_switch3),
        .pending          (pending3),
        .stop             (stop3),
        .err              (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] s, input logic [7:0] m, input logic [63:0] v,
                       input logic [15:0] r);
        update           = 1'b1;
        req_segment      = s;
        transition_mode  = m;
        transition_value = v;
        rep              = r;
        tick();
        update = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; update = 1'b0; req_segment = '0; transition_mode = '0;
        transition_value = '0; rep = '0; sys_time = '0; gpio_in = '0; loop_end = 1'b0;
        tick();
        tick();
        check("rst_segment", segment, 0);
        check("rst_switch", seg_switch, 0);
        check("rst_pending", pending, 0);
        check("rst_stop", stop, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Immediate commit, infinite repetitions
        req(2'd2, MODE_IMMEDIATE, 64'd0, 16'hFFFF);
        check("imm_pending", pending, 1);
        check("imm_seg_hold", segment, 0);
        tick();
        check("imm_segment", segment, 2);
        check("imm_switch", seg_switch, 1);
        check("imm_pending_clr", pending, 0);
        loop_end = 1'b1;
        repeat (3) tick();
        loop_end = 1'b0;
        tick();
        check("imm_switch_once", seg_switch, 0);
        check("imm_no_stop", stop, 0);

        // SYNC_IDX, REP=2: commit on 1st loop_end, stop after 4th
        req(2'd1, MODE_SYNC_IDX, 64'd0, 16'd2);
        check("sync_pending", pending, 1);
        loop_end = 1'b1;
        tick();
        check("sync_segment", segment, 1);
        check("sync_switch", seg_switch, 1);
        tick();
        tick();
        check("sync_not_stop", stop, 0);
        tick();
        loop_end = 1'b0;
        check("sync_stop", stop, 1);
        check("sync_seg_held", segment, 1);

        // SYS_TIME compare ramping from 990 to 1000
        sys_time = 64'd990;
        req(2'd3, MODE_SYS_TIME, 64'd1000, 16'hFFFF);
        for (int i = 1; i <= 10; i++) begin
            sys_time = 64'd990 + 64'(i);
            tick();
            if (i == 9) begin
                check("time_wait_seg", segment, 1);
                check("time_wait_stop", stop, 1);
            end
        end
        check("time_segment", segment, 3);
        check("time_switch", seg_switch, 1);
        check("time_stop_clr", stop, 0);

        // Time already past commits one cycle after arming
        req(2'd0, MODE_SYS_TIME, 64'd5, 16'hFFFF);
        tick();
        check("past_segment", segment, 0);
        check("past_switch", seg_switch, 1);

        // GPIO[2] high at arm is not an edge; fall then rise commits
        gpio_in = 4'b0100;
        tick();
        req(2'd2, MODE_GPIO, 64'd2, 16'hFFFF);
        tick();
        tick();
        check("gpio_level_pending", pending, 1);
        check("gpio_level_seg", segment, 0);
        gpio_in = 4'b0000;
        tick();
        check("gpio_fall_pending", pending, 1);
        gpio_in = 4'b0100;
        tick();
        check("gpio_segment", segment, 2);
        check("gpio_switch", seg_switch, 1);
        check("gpio_pending_clr", pending, 0);
        gpio_in = 4'b0000;

        // EXT with REP=0 auto-advances 3 -> 0 -> 1
        req(2'd3, MODE_EXT, 64'd0, 16'd0);
        loop_end = 1'b1;
        tick();
        check("ext_commit_seg", segment, 3);
        check("ext_commit_switch", seg_switch, 1);
        tick();
        check("ext_wrap_seg", segment, 0);
        check("ext_wrap_switch", seg_switch, 1);
        check("ext_no_stop", stop, 0);
        tick();
        check("ext_adv_seg", segment, 1);
        check("ext_adv_switch", seg_switch, 1);
        loop_end = 1'b0;
        tick();
        check("ext_idle_switch", seg_switch, 0);

        // Update coinciding with a trigger replaces the pending request
        req(2'd2, MODE_IMMEDIATE, 64'd0, 16'hFFFF);
        req(2'd0, MODE_IMMEDIATE, 64'd0, 16'hFFFF);
        check("race_seg", segment, 1);
        check("race_pending", pending, 1);
        check("race_switch", seg_switch, 0);
        tick();
        check("race_new_seg", segment, 0);
        check("race_new_switch", seg_switch, 1);

        // Rejected requests
        req(2'd2, 8'h05, 64'd0, 16'hFFFF);
        check("bad_mode_err", err, 1);
        check("bad_mode_seg", segment, 0);
        check("bad_mode_pending", pending, 0);
        check("bad_mode_err3", err3, 1);
        tick();
        check("err_sticky", err, 1);
        req(2'd3, MODE_IMMEDIATE, 64'd0, 16'hFFFF);
        check("ok_err_clr", err, 0);
        check("range_err3", err3, 1);
        tick();
        check("ok_segment", segment, 3);
        req(2'd1, MODE_IMMEDIATE, 64'd0, 16'hFFFF);
        check("ok_err3_clr", err3, 0);
        tick();

        // Reset while armed drops the request
        req(2'd2, MODE_SYNC_IDX, 64'd0, 16'hFFFF);
        check("rstarm_pending", pending, 1);
        rst_n = 1'b0;
        #1;
        check("rstarm_seg", segment, 0);
        check("rstarm_pending_clr", pending, 0);
        tick();
        rst_n = 1'b1;
        loop_end = 1'b1;
        tick();
        tick();
        loop_end = 1'b0;
        check("rstarm_no_switch", seg_switch, 0);
        check("rstarm_seg_after", segment, 0);
        check("rstarm_pending_after", pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
